// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: Rcon constants, GF(2^8) helpers and
// the key-expansion FSM state encoding.
package aes_pkg;

  localparam logic [7:0] AES_RCON_INIT  = 8'h01;
  localparam logic [7:0] AES_XTIME_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_XOR  = 2'd2
  } key_state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Handshake/data bundle between the round controller and the key schedule.
interface aes_key_expand_seq_if;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in,
    input  round_key, round_idx, key_valid, busy, done
  );

  modport slave (
    input  start, key_in,
    output round_key, round_idx, key_valid, busy, done
  );
endinterface

// File: rtl/S4.sv
// Four parallel AES S-boxes with a registered output (one-cycle lookup).
module S4 (
  input  logic        clk,
  input  logic [31:0] in,
  output logic [31:0] out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Data-path register only; its content is don't-care until the FSM uses it.
  always_ff @(posedge clk) begin
    out <= {SBOX[in[31:24]], SBOX[in[23:16]], SBOX[in[15:8]], SBOX[in[7:0]]};
  end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: one round key every two cycles
// (registered S4 lookup, then the XOR/output register stage).
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_key_expand_seq_if.slave  bus
);

  key_state_t   state;
  logic [127:0] key_q;
  logic [7:0]   rcon;
  logic [31:0]  s4_out;
  logic [31:0]  t_word;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [3:0]   idx_n;

  S4 u_s4 (
    .clk (clk),
    .in  (rot_word(key_q[31:0])),
    .out (s4_out)
  );

  always_comb begin
    t_word = s4_out ^ {rcon, 24'h0};
    w0_n   = key_q[127:96] ^ t_word;
    w1_n   = key_q[95:64]  ^ w0_n;
    w2_n   = key_q[63:32]  ^ w1_n;
    w3_n   = key_q[31:0]   ^ w2_n;
    idx_n  = bus.round_idx + 4'd1;
  end

  assign bus.busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      key_q         <= '0;
      rcon          <= AES_RCON_INIT;
      bus.round_key <= '0;
      bus.round_idx <= '0;
      bus.key_valid <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.key_valid <= 1'b0;
      bus.done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            key_q         <= bus.key_in;
            bus.round_key <= bus.key_in;
            bus.round_idx <= '0;
            bus.key_valid <= 1'b1;
            rcon          <= AES_RCON_INIT;
            state         <= ST_SUB;
          end
        end
        ST_SUB: state <= ST_XOR;
        ST_XOR: begin
          key_q         <= {w0_n, w1_n, w2_n, w3_n};
          bus.round_key <= {w0_n, w1_n, w2_n, w3_n};
          bus.round_idx <= idx_n;
          bus.key_valid <= 1'b1;
          rcon          <= xtime(rcon);
          // start is not looked at here, so a start coincident with done is dropped
          if (idx_n == 4'(NR)) begin
            bus.done <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            state <= ST_SUB;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Scoreboard bench for the iterative AES-128 key schedule.
module tb_aes_key_expand_seq;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           chk_key;
    bit           done;
    int           gap;
  } exp_t;

  localparam logic [127:0] K_FIPS    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_FIPS_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_FIPS_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_SEQ     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_SEQ_1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K_SEQ_10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K_ZERO    = 128'h0;
  localparam logic [127:0] K_ZERO_1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] K_ZERO_10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] K_ONES    = {128{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   last_valid = 0;
  int   n_valid = 0;
  exp_t sb[$];
  exp_t mon_e;

  aes_key_expand_seq_if bus ();

  aes_key_expand_seq #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic push_exp(input logic [127:0] k0, input logic [127:0] k1, input logic [127:0] k10,
                          input bit chk_mid, input int gap0);
    for (int i = 0; i <= 10; i++) begin
      exp_t e;
      e.idx     = 4'(i);
      e.done    = (i == 10);
      e.gap     = (i == 0) ? gap0 : 2;
      e.chk_key = (i == 0) || chk_mid;
      e.key     = (i == 0) ? k0 : (i == 1) ? k1 : k10;
      if (i > 1 && i < 10) e.chk_key = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic do_start(input logic [127:0] k, input logic [127:0] k1, input logic [127:0] k10,
                          input bit chk_mid);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = k;
    push_exp(k, k1, k10, chk_mid, 0);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !bus.busy) ok = 1'b1;
    end
    check({name, "_complete"}, {127'b0, ok}, 128'd1);
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_round_key"}, bus.round_key, 128'h0);
    check({name, "_round_idx"}, {124'b0, bus.round_idx}, 128'h0);
    check({name, "_flags"}, {125'b0, bus.key_valid, bus.busy, bus.done}, 128'h0);
  endtask

  // Monitor: pops the next expected key on every key_valid pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.key_valid) begin
        n_valid <= n_valid + 1;
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_valid idx=%0d required=no pulse", bus.round_idx);
        end else begin
          mon_e = sb.pop_front();
          check("round_idx", {124'b0, bus.round_idx}, {124'b0, mon_e.idx});
          check("done_at_valid", {127'b0, bus.done}, {127'b0, mon_e.done});
          if (mon_e.chk_key) check("round_key", bus.round_key, mon_e.key);
          if (mon_e.gap > 0) check("valid_spacing", 128'(cyc - last_valid), 128'(mon_e.gap));
        end
        last_valid <= cyc;
      end else if (bus.done) begin
        total++;
        $display("FAIL done_without_valid actual=1 required=0");
      end
    end
  end

  initial begin
    int nv0;
    bit seen;
    bus.start  = 1'b0;
    bus.key_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted between edges in the middle of an expansion
    do_start(K_FIPS, K_FIPS_1, K_FIPS_10, 1'b1);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    sb.delete();
    @(negedge clk);
    #1 rst = 1'b0;

    // FIPS-197 key
    nv0 = n_valid;
    do_start(K_FIPS, K_FIPS_1, K_FIPS_10, 1'b1);
    wait_idle("fips");
    check("fips_pulse_count", 128'(n_valid - nv0), 128'd11);
    repeat (3) @(posedge clk);
    #2 check("round_key_hold", bus.round_key, K_FIPS_10);

    // Sequential-byte key
    do_start(K_SEQ, K_SEQ_1, K_SEQ_10, 1'b1);
    wait_idle("seq");

    // start held high, key_in changed mid-expansion; restart right after done
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = K_FIPS;
    push_exp(K_FIPS, K_FIPS_1, K_FIPS_10, 1'b1, 0);
    push_exp(K_ONES, K_ONES, K_ONES, 1'b0, 1);
    @(posedge clk);
    #1 bus.key_in = K_ONES;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("held_start_done_seen", {127'b0, seen}, 128'd1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle("held_start");

    // Reset after the idx4 pulse, then a fresh expansion
    do_start(K_FIPS, K_FIPS_1, K_FIPS_10, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.key_valid && bus.round_idx == 4'd4) seen = 1'b1;
    end
    check("idx4_seen", {127'b0, seen}, 128'd1);
    #2 rst = 1'b1;
    sb.delete();
    #1 check_reset_outputs("reset_after_idx4");
    @(negedge clk);
    #1 rst = 1'b0;
    do_start(K_FIPS, K_FIPS_1, K_FIPS_10, 1'b1);
    wait_idle("after_reset");

    // All-zero and all-ones keys
    do_start(K_ZERO, K_ZERO_1, K_ZERO_10, 1'b1);
    wait_idle("zero");
    do_start(K_ONES, K_ONES, K_ONES, 1'b0);
    wait_idle("ones");
    repeat (4) @(posedge clk);
    #2 check("idx_saturates", {124'b0, bus.round_idx}, 128'd10);
    check("idle_after_done", {127'b0, bus.busy}, 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
